// File: rtl/perc_neuron_ctrl_pkg.sv
// Shared types for the perceptron datapath: data configuration, neuron FSM states and width helpers.
// DEF_DCONF_FXP is the default configuration: signed 16-bit fixed point with 8 fraction bits.
`ifndef DEF_DCONF_FXP
`define DEF_DCONF_FXP '{dtype: DT_FXP, sign: 1'b1, prec: 8'd16, frac: 8'd8}
`endif

package perc_neuron_ctrl_pkg;

    typedef enum logic [1:0] {DT_BOOL, DT_INT, DT_FXP, DT_FP} dtype_t;

    typedef struct packed {
        dtype_t     dtype;
        logic       sign;
        logic [7:0] prec;
        logic [7:0] frac;
    } dconf_t;

    typedef enum logic [1:0] {IDLE, ACC, ACT, OUT} neuron_state_t;

    // Full-precision products plus enough headroom for NIN of them and an aligned bias.
    function automatic int acc_width(input int prec, input int nin);
        return 2 * prec + $clog2(nin) + 1;
    endfunction

    function automatic int step_one(input dconf_t conf);
        return (conf.dtype == DT_FXP) ? (1 << conf.frac) : 1;
    endfunction

endpackage

// File: rtl/perc_neuron_ctrl_mac.sv
// Signed multiply-accumulate register: clear has priority over load, load over enable.
// One-cycle update; no handshake, the controller qualifies en with the input beat.
module perc_mac
    import perc_neuron_ctrl_pkg::*;
#(
    parameter int PREC = 16,
    parameter int ACCW = 37
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   clear,
    input  logic                   load,
    input  logic signed [ACCW-1:0] load_val,
    input  logic                   en,
    input  logic [PREC-1:0]        x,
    input  logic [PREC-1:0]        w,
    output logic signed [ACCW-1:0] acc
);

    logic signed [2*PREC-1:0] prod;

    assign prod = (2*PREC)'(signed'(x)) * (2*PREC)'(signed'(w));

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_val;
        end else if (en) begin
            acc <= acc + ACCW'(prod);
        end
    end

endmodule

// File: rtl/perc_neuron_ctrl.sv
// One perceptron neuron: accumulates NIN x*w beats, applies a step, presents y; PERC_NEURON_BIAS_EN adds a bias seed.
// Latency: start -> in_ready next cycle; last beat -> out_valid two cycles later; in_valid gaps stall, out_valid holds until out_ready.
module perc_neuron_ctrl
    import perc_neuron_ctrl_pkg::*;
#(
    parameter dconf_t CONF = `DEF_DCONF_FXP,
    parameter int     PREC = int'(CONF.prec),
    parameter int     NIN  = 8,
    parameter int     ACCW = acc_width(PREC, NIN)
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            start,
    output logic            busy,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PREC-1:0] in_x,
    input  logic [PREC-1:0] in_w,
`ifdef PERC_NEURON_BIAS_EN
    input  logic [PREC-1:0] bias,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PREC-1:0] out_y
);

    localparam int              FRAC = (CONF.dtype == DT_FXP) ? int'(CONF.frac) : 0;
    localparam int              CNTW = $clog2(NIN);
    localparam logic [PREC-1:0] ONE  = PREC'(step_one(CONF));

    if (!((CONF.dtype == DT_INT || CONF.dtype == DT_FXP) && CONF.sign)) begin : g_bad_conf
        $error("perc_neuron_ctrl: only signed INT or FXP data configurations are supported");
    end

    neuron_state_t          state, state_nxt;
    logic [CNTW-1:0]        cnt;
    logic                   beat;
    logic                   begin_eval;
    logic                   mac_clear;
    logic                   mac_load;
    logic signed [ACCW-1:0] seed;
    logic signed [ACCW-1:0] acc;

`ifdef PERC_NEURON_BIAS_EN
    // Bias shares the x format; shift it up to the product's 2*FRAC scale.
    assign seed = ACCW'(signed'(bias)) <<< FRAC;
`else
    assign seed = '0;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        begin_eval = 1'b0;
        beat       = 1'b0;
        case (state)
            IDLE: begin
                busy       = 1'b0;
                begin_eval = start;
                if (start) state_nxt = ACC;
            end
            ACC: begin
                in_ready = 1'b1;
                beat     = in_valid;
                if (in_valid && cnt == CNTW'(NIN - 1)) state_nxt = ACT;
            end
            ACT: state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PERC_NEURON_BIAS_EN
    assign mac_clear = 1'b0;
    assign mac_load  = begin_eval;
`else
    assign mac_clear = begin_eval;
    assign mac_load  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt   <= '0;
            out_y <= '0;
        end else begin
            if (begin_eval) begin
                cnt <= '0;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
            end
            // A zero sum fires the neuron.
            if (state == ACT) begin
                out_y <= (acc >= 0) ? ONE : '0;
            end
        end
    end

    perc_mac #(
        .PREC (PREC),
        .ACCW (ACCW)
    ) u_mac (
        .clk      (clk),
        .reset_   (reset_),
        .clear    (mac_clear),
        .load     (mac_load),
        .load_val (seed),
        .en       (beat),
        .x        (in_x),
        .w        (in_w),
        .acc      (acc)
    );

endmodule

// File: tb/tb_perc_neuron_ctrl.sv
// Directed bench for perc_neuron_ctrl at PREC=16, Q8.8 fixed point, NIN=4.
module tb_perc_neuron_ctrl;

    logic        clk = 1'b0;
    logic        reset_;
    logic        start;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_w;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    perc_neuron_ctrl #(.NIN(4)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
`ifdef PERC_NEURON_BIAS_EN
        .bias      (bias),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input logic [3:0][15:0] xs, input logic [3:0][15:0] ws,
                           input bit gaps, input int hold, input logic [15:0] exp);
        int i = 0;
        int cyc = 0;
        bit hs;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_in_ready_after_start"}, in_ready, 1);
        check({tag, "_busy"}, busy, 1);
        while (i < 4 && cyc < 64) begin
            in_valid = !(gaps && (cyc % 2) != 0);
            in_x     = xs[i];
            in_w     = ws[i];
            hs       = in_valid && in_ready;
            @(negedge clk);
            if (hs) i++;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_beats_done"}, i, 4);
        if (gaps) check({tag, "_gap_cycles"}, cyc, 7);
        check({tag, "_act_out_valid"}, out_valid, 0);
        check({tag, "_act_in_ready"}, in_ready, 0);
        @(negedge clk);
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_out_y"}, out_y, exp);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_y"}, out_y, exp);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_out_valid"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_start_in_out_ignored"}, busy, 0);
    endtask

    localparam logic [3:0][15:0] X1 = {16'h0080, 16'hFF00, 16'h0200, 16'h0100};
    localparam logic [3:0][15:0] X3 = {16'h0000, 16'h0000, 16'hFF00, 16'h0100};
    localparam logic [3:0][15:0] WP = {4{16'h0100}};
    localparam logic [3:0][15:0] WN = {4{16'hFF00}};

    initial begin
        reset_ = 1'b0; start = 1'b0; in_valid = 1'b0; in_x = '0; in_w = '0;
        bias = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        reset_ = 1'b1;

        in_valid = 1'b1; in_x = 16'h7F00; in_w = 16'h7F00;
        repeat (3) @(negedge clk);
        check("idle_in_valid_ready", in_ready, 0);
        check("idle_in_valid_busy", busy, 0);
        in_valid = 1'b0;

        run_vec("pos", X1, WP, 1'b0, 0, 16'h0100);
        run_vec("neg", X1, WN, 1'b0, 0, 16'h0000);
        run_vec("zero", X3, WP, 1'b0, 0, 16'h0100);
        run_vec("gaps", X1, WP, 1'b1, 3, 16'h0100);

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1; in_x = 16'hFF00; in_w = 16'h7F00;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        reset_ = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_y", out_y, 0);
        @(negedge clk); reset_ = 1'b1;
        run_vec("fresh", X1, WP, 1'b0, 0, 16'h0100);

`ifdef PERC_NEURON_BIAS_EN
        bias = 16'hFD00;
        run_vec("bias", X1, WP, 1'b0, 0, 16'h0000);
        bias = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
